// File: rtl/mem_scheduler_if.sv
// mem_scheduler_if
// Groups the client request/done/grant signals and the buffer-index outputs
// of the memory time-slot scheduler.
//   master : the scheduler side (takes requests, dones and frame_flag; drives
//            grants, busy, frame_swap, buffer indices and err_timeout)
//   slave  : the client / memory_interface side (the mirror image)
interface mem_scheduler_if;
  logic       ntsc_req;
  logic       lpf_req;
  logic       pt_req;
  logic       vga_req;
  logic       done_ntsc;
  logic       done_lpf;
  logic       done_pt;
  logic       done_vga;
  logic       frame_flag;
  logic       ntsc_flag;
  logic       lpf_flag;
  logic       pt_flag;
  logic       vga_flag;
  logic       busy;
  logic       frame_swap;
  logic [1:0] cap_buf;
  logic [1:0] proc_buf;
  logic [1:0] disp_buf;
  logic       err_timeout;

  modport master (
    input  ntsc_req, lpf_req, pt_req, vga_req,
    input  done_ntsc, done_lpf, done_pt, done_vga,
    input  frame_flag,
    output ntsc_flag, lpf_flag, pt_flag, vga_flag,
    output busy, frame_swap, cap_buf, proc_buf, disp_buf, err_timeout
  );

  modport slave (
    output ntsc_req, lpf_req, pt_req, vga_req,
    output done_ntsc, done_lpf, done_pt, done_vga,
    output frame_flag,
    input  ntsc_flag, lpf_flag, pt_flag, vga_flag,
    input  busy, frame_swap, cap_buf, proc_buf, disp_buf, err_timeout
  );
endinterface

// File: rtl/mem_scheduler.sv
// mem_scheduler
// Time-slot arbiter for the shared ZBT banks. Four clients (VGA readout, NTSC
// capture, LPF, projective transform) raise level requests; one grant at a
// time is held until that client's done pulse or until TIMEOUT expires.
// End-of-frame pulses are remembered and turned into a one-cycle buffer
// rotation between grants, which updates the triple-buffer indices.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : mem_scheduler_if.master (requests, dones, frame_flag in;
//            grant flags, busy, frame_swap, buffer indices, err_timeout out)
// Parameter:
//   TIMEOUT : longest a grant may stay open without done (1..255); the flag
//             is high for TIMEOUT+1 cycles in that case.
module mem_scheduler #(
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  mem_scheduler_if.master  bus
);

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CL_VGA  = 2'd0,
    CL_NTSC = 2'd1,
    CL_LPF  = 2'd2,
    CL_PT   = 2'd3
  } client_t;

  state_t     r_state;
  state_t     w_nextState;
  client_t    r_client;
  client_t    w_nextClient;
  logic       r_rr;
  logic       w_nextRr;
  logic [7:0] r_timer;
  logic [7:0] w_nextTimer;
  logic       r_err;
  logic       w_nextErr;
  logic       r_pending;
  logic       w_swap;
  logic       w_done;
  logic [1:0] r_capBuf;
  logic [1:0] r_procBuf;
  logic [1:0] r_dispBuf;

  // Done from the client currently holding the grant; other dones are ignored.
  always_comb begin
    w_done = 1'b0;
    case (r_client)
      CL_VGA:  w_done = bus.done_vga;
      CL_NTSC: w_done = bus.done_ntsc;
      CL_LPF:  w_done = bus.done_lpf;
      CL_PT:   w_done = bus.done_pt;
      default: w_done = 1'b0;
    endcase
  end

  // Next-state logic. A pending frame rotation is serviced from IDLE before
  // any new grant. rr = 0 favours lpf, rr = 1 favours pt; after an lpf/pt
  // grant it points at the side that did not just win.
  always_comb begin
    w_nextState  = r_state;
    w_nextClient = r_client;
    w_nextRr     = r_rr;
    w_nextTimer  = r_timer;
    w_nextErr    = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nextTimer = 8'd0;
        if (r_pending) begin
          w_nextState = ST_SWAP;
        end else if (bus.vga_req) begin
          w_nextState  = ST_GRANT;
          w_nextClient = CL_VGA;
        end else if (bus.ntsc_req) begin
          w_nextState  = ST_GRANT;
          w_nextClient = CL_NTSC;
        end else if (bus.lpf_req && (!bus.pt_req || !r_rr)) begin
          w_nextState  = ST_GRANT;
          w_nextClient = CL_LPF;
          w_nextRr     = 1'b1;
        end else if (bus.pt_req) begin
          w_nextState  = ST_GRANT;
          w_nextClient = CL_PT;
          w_nextRr     = 1'b0;
        end
      end
      ST_GRANT: begin
        if (w_done) begin
          w_nextState = ST_IDLE;
        end else if (r_timer == LP_TIMEOUT) begin
          w_nextState = ST_IDLE;
          w_nextErr   = 1'b1;
        end else begin
          w_nextTimer = r_timer + 8'd1;
        end
      end
      ST_SWAP: begin
        w_swap      = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // FSM state, granted client, round-robin pointer, grant timer, error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_client <= CL_VGA;
      r_rr     <= 1'b0;
      r_timer  <= 8'd0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_client <= w_nextClient;
      r_rr     <= w_nextRr;
      r_timer  <= w_nextTimer;
      r_err    <= w_nextErr;
    end
  end

  // Pending rotation: a new frame_flag beats the clear in SWAP so a frame
  // arriving exactly during the rotation is not lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (bus.frame_flag) begin
      r_pending <= 1'b1;
    end else if (w_swap) begin
      r_pending <= 1'b0;
    end
  end

  // Triple-buffer rotation: display takes the freshly processed buffer,
  // processing takes the just-captured one, capture reuses the old display.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_capBuf  <= 2'd0;
      r_procBuf <= 2'd1;
      r_dispBuf <= 2'd2;
    end else if (w_swap) begin
      r_dispBuf <= r_procBuf;
      r_procBuf <= r_capBuf;
      r_capBuf  <= r_dispBuf;
    end
  end

  assign bus.vga_flag    = (r_state == ST_GRANT) && (r_client == CL_VGA);
  assign bus.ntsc_flag   = (r_state == ST_GRANT) && (r_client == CL_NTSC);
  assign bus.lpf_flag    = (r_state == ST_GRANT) && (r_client == CL_LPF);
  assign bus.pt_flag     = (r_state == ST_GRANT) && (r_client == CL_PT);
  assign bus.busy        = bus.vga_flag | bus.ntsc_flag | bus.lpf_flag | bus.pt_flag;
  assign bus.frame_swap  = w_swap;
  assign bus.err_timeout = r_err;
  assign bus.cap_buf     = r_capBuf;
  assign bus.proc_buf    = r_procBuf;
  assign bus.disp_buf    = r_dispBuf;

endmodule
